// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   OVERSAMPLE        - divider ticks per bit (fixed at 16)
//   DEFAULT_CLK_FREQ  - default system clock frequency in Hz
//   DEFAULT_BAUD_RATE - default line rate in bit/s
//   rx_state_t        - receiver FSM state encoding
//   majority3()       - 2-of-3 vote used to filter single-sample glitches
package uart_pkg;

    localparam int OVERSAMPLE        = 16;
    localparam int DEFAULT_CLK_FREQ  = 100_000_000;
    localparam int DEFAULT_BAUD_RATE = 9600;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-cycle tick every DIV clocks.
//   clk  - system clock
//   rst  - asynchronous active-low reset (counter restarts at 0)
//   tick - high for one clock when the counter reaches DIV-1
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 16x oversampled UART receiver (8N1, LSB first).
//   clk       - system clock
//   rst       - asynchronous active-low reset
//   rx        - asynchronous serial line, idle high
//   rx_data   - last correctly received byte, held until the next rx_done
//   rx_done   - one-cycle strobe, rx_data newly valid
//   frame_err - one-cycle strobe, stop bit sampled low (rx_data untouched)
//   rx_busy   - high while a frame is in progress
module uart_rx_oversampled #(
    parameter int CLK_FREQ   = uart_pkg::DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE  = uart_pkg::DEFAULT_BAUD_RATE,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);
    import uart_pkg::*;

    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);

    logic       rx_meta;
    logic       rx_s;
    logic       rx_q;
    logic       tick;

    rx_state_t  state;
    rx_state_t  state_nxt;
    logic [3:0] tick_cnt;
    logic [3:0] tick_cnt_nxt;
    logic [2:0] bit_idx;
    logic [2:0] bit_idx_nxt;
    logic [7:0] shift;
    logic [1:0] samp;
    logic       vote;
    logic       take_sample;
    logic       shift_en;
    logic       done_nxt;
    logic       ferr_nxt;

    // Synchronizer stages reset to the idle level so reset release never
    // looks like a start bit on an idle line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // The first two window samples are stored; the third is the live rx_s
    // on the decision tick.
    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_idx_nxt  = bit_idx;
        take_sample  = 1'b0;
        shift_en     = 1'b0;
        done_nxt     = 1'b0;
        ferr_nxt     = 1'b0;
        vote         = majority3(samp[1], samp[0], rx_s);

        case (state)
            IDLE: begin
                if (rx_q && !rx_s) begin
                    state_nxt    = START;
                    tick_cnt_nxt = '0;
                end
            end
            START: begin
                if (tick) begin
                    tick_cnt_nxt = tick_cnt + 4'd1;
                    take_sample  = (tick_cnt == 4'd5) || (tick_cnt == 4'd6);
                    // Mid start bit: from here on every 16th tick is mid-bit.
                    if (tick_cnt == 4'd7) begin
                        if (vote) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt    = DATA;
                            tick_cnt_nxt = '0;
                            bit_idx_nxt  = '0;
                        end
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    // 4-bit counter wraps 15 -> 0 at each bit boundary.
                    tick_cnt_nxt = tick_cnt + 4'd1;
                    take_sample  = (tick_cnt == 4'd13) || (tick_cnt == 4'd14);
                    if (tick_cnt == 4'd15) begin
                        shift_en = 1'b1;
                        if (bit_idx == 3'd7) begin
                            state_nxt = STOP;
                        end else begin
                            bit_idx_nxt = bit_idx + 3'd1;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    tick_cnt_nxt = tick_cnt + 4'd1;
                    take_sample  = (tick_cnt == 4'd13) || (tick_cnt == 4'd14);
                    // Deciding mid stop bit leaves half a bit to catch a
                    // back-to-back start edge in IDLE.
                    if (tick_cnt == 4'd15) begin
                        state_nxt = IDLE;
                        done_nxt  = vote;
                        ferr_nxt  = !vote;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            rx_data   <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            rx_done   <= done_nxt;
            frame_err <= ferr_nxt;
            if (done_nxt) begin
                rx_data <= shift;
            end
        end
    end

    // Sample history and shift register are fully rewritten within each
    // frame before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (take_sample) begin
            samp <= {samp[0], rx_s};
        end
        if (shift_en) begin
            shift <= {vote, shift[7:1]};
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: self-checking bench for uart_rx_oversampled.
// Runs at a scaled clock/baud ratio (3 clocks per tick, 48 clocks per bit);
// the line is driven from per-clock waveforms built from byte values, and
// received bytes are compared against an expected-byte queue.
module tb_uart_rx_oversampled;

    localparam int CLK_FREQ  = 460_800;
    localparam int BAUD_RATE = 9600;
    localparam int DIV       = CLK_FREQ / (BAUD_RATE * 16);
    localparam int BIT       = DIV * 16;
    localparam int LAT_MIN   = (19 * BIT) / 2;
    localparam int LAT_MAX   = LAT_MIN + 3 + DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         edge_cyc;
    int         ferr_cnt  = 0;
    int         exp_ferr  = 0;
    logic [7:0] last_good = 8'h00;
    logic       busy_seen = 1'b0;
    logic       prev_done = 1'b0;
    logic [7:0] prev_data = 8'h00;

    logic       wave[$];
    logic [7:0] done_q[$];
    int         done_cyc[$];
    logic [7:0] exp_q[$];

    uart_rx_oversampled #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: records strobes and checks strobe-level invariants.
    always @(negedge clk) begin
        if (rst) begin
            if (rx_done) begin
                done_q.push_back(rx_data);
                done_cyc.push_back(cyc);
                check_eq("done_single_cycle", {31'd0, prev_done}, 32'd0);
            end
            if (frame_err) ferr_cnt++;
            if (rx_done || frame_err)
                check_eq("strobe_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
            if (rx_data !== prev_data)
                check_eq("data_changes_with_done", {31'd0, rx_done}, 32'd1);
            if (rx_busy) busy_seen = 1'b1;
        end
        prev_done = rx_done;
        prev_data = rx_data;
    end

    task automatic build_frame(input logic [7:0] b, input logic stop_lvl, input int bitlen);
        repeat (bitlen) wave.push_back(1'b0);
        for (int n = 0; n < 8; n++) repeat (bitlen) wave.push_back(b[n]);
        repeat (bitlen) wave.push_back(stop_lvl);
    endtask

    task automatic build_idle(input int n);
        repeat (n) wave.push_back(1'b1);
    endtask

    // Drives the queued waveform one level per clock; optionally asserts
    // reset at index reset_at and checks that outputs clear at once.
    task automatic play(input int reset_at);
        edge_cyc = -1;
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge clk);
            rx = wave[i];
            if (edge_cyc < 0 && wave[i] == 1'b0) edge_cyc = cyc;
            if (i == reset_at) begin
                rst = 1'b0;
                #1;
                check_eq("rst_mid_rx_data",   {24'd0, rx_data},   32'h00);
                check_eq("rst_mid_rx_done",   {31'd0, rx_done},   32'd0);
                check_eq("rst_mid_frame_err", {31'd0, frame_err}, 32'd0);
                check_eq("rst_mid_rx_busy",   {31'd0, rx_busy},   32'd0);
            end
        end
        wave.delete();
    endtask

    // Lets the line idle, then compares everything received against the model.
    task automatic settle(input string tag);
        repeat (2 * BIT + 10) @(negedge clk);
        check_eq({tag, "_count"}, done_q.size(), exp_q.size());
        while (done_q.size() > 0 && exp_q.size() > 0)
            check_eq({tag, "_data"}, {24'd0, done_q.pop_front()}, {24'd0, exp_q.pop_front()});
        done_q.delete();
        exp_q.delete();
        check_eq({tag, "_ferr_total"}, ferr_cnt, exp_ferr);
        check_eq({tag, "_busy_idle"}, {31'd0, rx_busy}, 32'd0);
        check_eq({tag, "_rx_data"}, {24'd0, rx_data}, {24'd0, last_good});
    endtask

    initial begin
        #(150_000 * 10);
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int gap;
        logic [7:0] b;

        repeat (5) @(negedge clk);
        check_eq("reset_rx_data",   {24'd0, rx_data},   32'h00);
        check_eq("reset_rx_done",   {31'd0, rx_done},   32'd0);
        check_eq("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check_eq("reset_rx_busy",   {31'd0, rx_busy},   32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // False start: short low pulse, rejected by the start-bit vote.
        busy_seen = 1'b0;
        repeat (2 * DIV) wave.push_back(1'b0);
        build_idle(1);
        play(-1);
        for (int w = 0; w < 8 * DIV + 5 && rx_busy; w++) @(negedge clk);
        check_eq("false_start_busy_seen", {31'd0, busy_seen}, 32'd1);
        check_eq("false_start_busy_drop", {31'd0, rx_busy},   32'd0);
        settle("false_start");

        // Single byte with latency bound.
        done_cyc.delete();
        build_frame(8'hA5, 1'b1, BIT);
        build_idle(4);
        play(-1);
        exp_q.push_back(8'hA5);
        last_good = 8'hA5;
        settle("single");
        lat = (done_cyc.size() > 0) ? done_cyc[0] - edge_cyc : -1;
        check_eq("single_latency_in_range", {31'd0, (lat >= LAT_MIN && lat <= LAT_MAX)}, 32'd1);

        // Framing error, then a good byte.
        build_frame(8'h3C, 1'b0, BIT);
        build_idle(2 * BIT);
        play(-1);
        exp_ferr++;
        settle("frame_err");
        build_frame(8'h81, 1'b1, BIT);
        build_idle(4);
        play(-1);
        exp_q.push_back(8'h81);
        last_good = 8'h81;
        settle("after_ferr");

        // One-tick inverted glitch near the middle of data bit 3.
        build_frame(8'h55, 1'b1, BIT);
        for (int j = 0; j < DIV; j++)
            wave[4 * BIT + 18 + j] = ~wave[4 * BIT + 18 + j];
        build_idle(4);
        play(-1);
        exp_q.push_back(8'h55);
        last_good = 8'h55;
        settle("glitch");

        // Back-to-back frames with no idle gap.
        done_cyc.delete();
        build_frame(8'h00, 1'b1, BIT);
        build_frame(8'hFF, 1'b1, BIT);
        build_idle(4);
        play(-1);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        last_good = 8'hFF;
        settle("b2b");
        lat = (done_cyc.size() == 2) ? done_cyc[1] - done_cyc[0] : -1;
        check_eq("b2b_spacing", {31'd0, (lat >= 10 * BIT - DIV && lat <= 10 * BIT + DIV)}, 32'd1);

        // Reset in the middle of data bit 4, then a fresh byte.
        build_frame(8'hC3, 1'b1, BIT);
        build_idle(4);
        play(5 * BIT + BIT / 2);
        repeat (BIT) @(negedge clk);
        rst = 1'b1;
        last_good = 8'h00;
        repeat (5) @(negedge clk);
        build_frame(8'h7E, 1'b1, BIT);
        build_idle(4);
        play(-1);
        exp_q.push_back(8'h7E);
        last_good = 8'h7E;
        settle("after_reset");

        // Random bytes with small baud mismatch and random idle gaps.
        for (int k = 0; k < 100; k++) begin
            b   = 8'($urandom_range(0, 255));
            gap = int'($urandom_range(0, 8));
            build_frame(b, 1'b1, int'($urandom_range(BIT - 1, BIT + 1)));
            build_idle(gap);
            play(-1);
            exp_q.push_back(b);
            last_good = b;
        end
        settle("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

UART receiver with 16x oversampling that turns the serial `rx` line into parallel bytes for the rest of the design. It sits directly upstream of the RX FIFO/loopback path inside `uart_top`. It delivers each received byte with a one-cycle `rx_done` strobe. It rejects false start bits, filters single-sample glitches by majority vote, and flags framing errors.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s.
- `OVERSAMPLE`, 16: ticks per bit; fixed at 16, other values unsupported.
- `clk`  input  1: system clock; all logic on rising edge.
- `rst`  input  1: reset, asynchronous, active-low (0 = reset).
- `rx`  input  1: asynchronous serial line, idle high.
- `rx_data`  output  8: last correctly received byte; reset 8'h00.
- `rx_done`  output  1: one-cycle strobe, `rx_data` newly valid; reset 0.
- `frame_err`  output  1: one-cycle strobe, stop bit sampled low; reset 0.
- `rx_busy`  output  1: high while a frame is in progress; reset 0.

## Operation
- **Synchronizer:** `rx` passes through a 2-FF synchronizer (both FFs reset to 1), giving `rx_s`. The previous value is held as `rx_q` (reset 1).
- **Tick divider:** `DIV = CLK_FREQ/(BAUD_RATE*16)`, integer-truncated (651 at the defaults, so one bit = 10416 clocks).
  - The counter runs 0..DIV-1 and pulses `tick` when it equals DIV-1.
  - It is free-running and resets to 0.
- **FSM states:** IDLE, START, DATA, STOP. A 4-bit `tick_cnt` counts ticks within the current state or bit. A 3-bit `bit_idx` tracks the data bit.
- **IDLE:**
  - Transition to START only on a falling edge (`rx_q`=1, `rx_s`=0); `tick_cnt`=0.
  - A line held low never retriggers.
- **START:**
  - Take majority of `rx_s` sampled at ticks with `tick_cnt` 5, 6, 7.
  - Decide at `tick_cnt`=7. If the majority is 1 (false start), go to IDLE. Otherwise `tick_cnt`=0 and go to DATA with `bit_idx`=0.
- **DATA:**
  - Take majority of samples at `tick_cnt` 13, 14, 15. This window sits at mid-bit because sampling is phase-aligned to mid start bit.
  - At `tick_cnt`=15, shift the result into `shift[7]` (LSB-first, right shift).
  - After `bit_idx`=7, go to STOP; otherwise increment `bit_idx`.
- **STOP:** same 13/14/15 majority, decided at `tick_cnt`=15.
  - Majority 1: `rx_data`<=`shift`, pulse `rx_done`.
  - Majority 0: pulse `frame_err`; `rx_data` is unchanged and there is no `rx_done`.
  - Go to IDLE in both cases.
- **`rx_busy`:** equals (state != IDLE).
- **Reset:** asserting reset mid-frame returns immediately to IDLE with all outputs at reset values. A frame partially seen at reset release is ignored until the next falling edge.

## Timing
- `rx_done`/`frame_err` rise on the clock edge after the stop-bit decision tick and stay high for exactly 1 cycle.
- `rx_data` changes on the same edge as `rx_done` and is held until the next `rx_done`.
- Latency from the `rx` falling edge to `rx_done`:
  - Nominal 9.5 bit periods (about 99k clocks at the defaults).
  - Plus 2-3 clocks for the synchronizer and edge detect.
  - Plus up to 1 tick of divider phase jitter.
- The decision point is mid stop bit, so a following start bit (back-to-back frames, no idle gap) is caught in IDLE.
- `rx_done` and `frame_err` are never high in the same cycle.
- Tolerated baud mismatch is at least ±3%.

## Structure
- **Package `uart_pkg`:**
  - `rx_state_t` enum (IDLE, START, DATA, STOP).
  - `OVERSAMPLE`=16.
  - Majority-of-3 function.
  - Default `CLK_FREQ`/`BAUD_RATE`, shared with the TX side.
- **Sub-module `uart_baud_tick`:**
  - Parameterised free-running divider with output `tick`.
  - Reused by the transmitter (which uses every 16th tick).

## Test plan
- **Single byte:** send 0xA5 at BIT_PERIOD=104160 ns → exactly one `rx_done`; `rx_data`=0xA5; `frame_err` never high; `rx_busy` low after the strobe.
- **False start:** `rx` low for 3000 ns then high → `rx_busy` drops within 8 ticks; no `rx_done`/`frame_err`; `rx_data` stays 0x00.
- **Framing error:** 0x3C sent with stop bit 0, then line high 2 bit periods → one `frame_err`, no `rx_done`, `rx_data` unchanged. A following 0x81 is received correctly.
- **Glitch filtering:** 0x55 with a 651-clock inverted pulse centred on tick 14 of data bit 3 → `rx_data`=0x55.
- **Back-to-back:** 0x00 then 0xFF with no idle gap → two `rx_done` strobes about 10416×10 clocks apart, data 0x00 then 0xFF.
- **Reset and random:**
  - Reset asserted mid data bit 4 → all outputs at reset values immediately; next byte 0x7E is received correctly.
  - 100 random bytes → 100 passes, 0 fails.
